calc_seq_ctrl: RTL and testbench

CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

---
 rtl/calc_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// calc_seq_ctrl
//   Sequencer for a small register-file calculator datapath. A command is
//   accepted from IDLE on Go. It may first load two external operands into the
//   register file, then reads both sources, executes the ALU op and writes the
//   result to the destination register. Illegal op codes divert to an error
//   state that raises a sticky Err flag instead of writing anything.
//
// Ports
//   CLK, RST_n        rising-edge clock, asynchronous active-low reset
//   Go                start request, sampled only in IDLE
//   Op                ALU op code, captured on acceptance
//   Load              1 = load two external operands before executing
//   SrcA, SrcB, Dst   operand / destination addresses, captured on acceptance
//   CS_out            current state code
//   s1                write-data mux select (00 ALU, 11 input 1, 10 input 2)
//   WA, WE            register-file write address / enable
//   RAA, RAB          register-file read addresses
//   REA, REB          register-file read enables
//   c                 ALU function select
//   s2                output mux (0 display register, 1 ALU path)
//   Busy              high whenever not in IDLE
//   Done_out          one-cycle completion pulse
//   Err               sticky illegal-op flag, cleared on the next acceptance
// -----------------------------------------------------------------------------
module calc_seq_ctrl #(
    parameter int AW      = 2,
    parameter int NUM_OPS = 6
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          Go,
    input  logic [2:0]    Op,
    input  logic          Load,
    input  logic [AW-1:0] SrcA,
    input  logic [AW-1:0] SrcB,
    input  logic [AW-1:0] Dst,
    output logic [3:0]    CS_out,
    output logic [1:0]    s1,
    output logic [AW-1:0] WA,
    output logic          WE,
    output logic [AW-1:0] RAA,
    output logic [AW-1:0] RAB,
    output logic          REA,
    output logic          REB,
    output logic [2:0]    c,
    output logic          s2,
    output logic          Busy,
    output logic          Done_out,
    output logic          Err
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD1 = 4'd1,
        S_LOAD2 = 4'd2,
        S_WAIT  = 4'd3,
        S_EXEC  = 4'd4,
        S_DONE  = 4'd5,
        S_ERR   = 4'd6
    } state_t;

    localparam logic [3:0] NUM_OPS_L = 4'(NUM_OPS);

    state_t        state_q, state_d;
    logic [2:0]    op_q;
    logic [AW-1:0] src_a_q, src_b_q, dst_q;
    logic          load_q;
    logic          op_legal;
    logic          accept;

    assign accept   = (state_q == S_IDLE) && Go;
    assign op_legal = ({1'b0, op_q} < NUM_OPS_L);

    // State register and command capture. The state register carries the
    // asynchronous reset so every Moore output drops to its IDLE value (WE=0
    // in particular) the moment RST_n falls, without waiting for CLK.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbours; blocking here would chain them.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= Op;
                src_a_q <= SrcA;
                src_b_q <= SrcB;
                dst_q   <= Dst;
                load_q  <= Load;
            end
        end
    end

    // Err is the only registered output: set while leaving WAIT on an illegal
    // op, held through ERR and IDLE, and cleared by the next accepted Go.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Err <= 1'b0;
        end else if (accept) begin
            Err <= 1'b0;
        end else if (state_q == S_WAIT && !op_legal) begin
            Err <= 1'b1;
        end
    end

    // Next-state and Moore output decode.
    // NOTE: every signal gets its IDLE value before the case statement, so no
    // path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        s1       = 2'b00;
        WA       = dst_q;
        WE       = 1'b0;
        RAA      = dst_q;
        RAB      = dst_q;
        REA      = 1'b1;
        REB      = 1'b1;
        c        = 3'b000;
        s2       = 1'b0;
        Done_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Go) state_d = Load ? S_LOAD1 : S_WAIT;
            end
            S_LOAD1: begin
                WE = 1'b1;
                s1 = 2'b11;
                WA = src_a_q;
                // LOAD1 is only entered with load_q set; the guard keeps the
                // captured flag consistent with the path actually taken.
                state_d = load_q ? S_LOAD2 : S_IDLE;
            end
            S_LOAD2: begin
                WE      = 1'b1;
                s1      = 2'b10;
                WA      = src_b_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                RAA     = src_a_q;
                RAB     = src_b_q;
                s2      = 1'b1;
                state_d = op_legal ? S_EXEC : S_ERR;
            end
            S_EXEC: begin
                WE      = 1'b1;
                s1      = 2'b00;
                WA      = dst_q;
                RAA     = src_a_q;
                RAB     = src_b_q;
                c       = op_q;
                s2      = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                Done_out = 1'b1;
                state_d  = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            // Unused codes 7..15 fall back to IDLE on the next edge.
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign CS_out = state_q;
    assign Busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_seq_ctrl
//   Self-checking bench for calc_seq_ctrl. The reference model describes each
//   command as the list of phases it must walk through (optional two loads,
//   read, then execute+done or error) and the outputs each phase must show.
//   A second instance built with AW=3 covers the wide-address case.
// -----------------------------------------------------------------------------
module tb_calc_seq_ctrl;

    localparam int AW      = 2;
    localparam int NUM_OPS = 6;

    // Phase codes as the state codes the block must report.
    localparam int P_LOAD1 = 1;
    localparam int P_LOAD2 = 2;
    localparam int P_WAIT  = 3;
    localparam int P_EXEC  = 4;
    localparam int P_DONE  = 5;
    localparam int P_ERR   = 6;

    typedef struct packed {
        logic          load;
        logic [2:0]    op;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] dst;
    } cmd_t;

    logic          CLK   = 1'b0;
    logic          RST_n = 1'b0;
    logic          Go    = 1'b0;
    logic [2:0]    Op    = '0;
    logic          Load  = 1'b0;
    logic [AW-1:0] SrcA  = '0;
    logic [AW-1:0] SrcB  = '0;
    logic [AW-1:0] Dst   = '0;
    logic [3:0]    CS_out;
    logic [1:0]    s1;
    logic [AW-1:0] WA, RAA, RAB;
    logic          WE, REA, REB, s2, Busy, Done_out, Err;
    logic [2:0]    c;

    // Wide-address instance signals.
    logic          go3   = 1'b0;
    logic [2:0]    op3   = '0;
    logic          load3 = 1'b0;
    logic [2:0]    a3 = '0, b3 = '0, d3 = '0;
    logic [3:0]    cs3;
    logic [1:0]    s1_3;
    logic [2:0]    wa3, raa3, rab3;
    logic          we3, rea3, reb3, s2_3, busy3, done3, err3;
    logic [2:0]    c3;

    int n_checks = 0;
    int n_errors = 0;

    // Model state carried between commands.
    logic          model_err = 1'b0;
    logic [AW-1:0] model_dst = '0;

    calc_seq_ctrl #(.AW(AW), .NUM_OPS(NUM_OPS)) u_dut (
        .CLK(CLK), .RST_n(RST_n), .Go(Go), .Op(Op), .Load(Load),
        .SrcA(SrcA), .SrcB(SrcB), .Dst(Dst),
        .CS_out(CS_out), .s1(s1), .WA(WA), .WE(WE), .RAA(RAA), .RAB(RAB),
        .REA(REA), .REB(REB), .c(c), .s2(s2), .Busy(Busy),
        .Done_out(Done_out), .Err(Err)
    );

    calc_seq_ctrl #(.AW(3), .NUM_OPS(NUM_OPS)) u_dut_aw3 (
        .CLK(CLK), .RST_n(RST_n), .Go(go3), .Op(op3), .Load(load3),
        .SrcA(a3), .SrcB(b3), .Dst(d3),
        .CS_out(cs3), .s1(s1_3), .WA(wa3), .WE(we3), .RAA(raa3), .RAB(rab3),
        .REA(rea3), .REB(reb3), .c(c3), .s2(s2_3), .Busy(busy3),
        .Done_out(done3), .Err(err3)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Outputs that IDLE must present.
    task automatic check_idle();
        check("idle_cs",   32'(CS_out),   32'd0);
        check("idle_busy", 32'(Busy),     32'd0);
        check("idle_we",   32'(WE),       32'd0);
        check("idle_done", 32'(Done_out), 32'd0);
        check("idle_s1",   32'(s1),       32'd0);
        check("idle_s2",   32'(s2),       32'd0);
        check("idle_c",    32'(c),        32'd0);
        check("idle_rea",  32'(REA),      32'd1);
        check("idle_reb",  32'(REB),      32'd1);
        check("idle_raa",  32'(RAA),      32'(model_dst));
        check("idle_rab",  32'(RAB),      32'(model_dst));
        check("idle_err",  32'(Err),      32'(model_err));
    endtask

    // Outputs expected in one busy phase of a command.
    task automatic check_phase(input int p, input cmd_t cmd);
        check($sformatf("cs@%0d", p),   32'(CS_out),   32'(p));
        check($sformatf("busy@%0d", p), 32'(Busy),     32'd1);
        check($sformatf("done@%0d", p), 32'(Done_out), 32'(p == P_DONE));
        check($sformatf("we@%0d", p),   32'(WE),
              32'(p == P_LOAD1 || p == P_LOAD2 || p == P_EXEC));
        if (p != P_ERR) check($sformatf("err@%0d", p), 32'(Err), 32'd0);
        case (p)
            P_LOAD1: begin
                check("load1_s1", 32'(s1), 32'h3);
                check("load1_wa", 32'(WA), 32'(cmd.a));
            end
            P_LOAD2: begin
                check("load2_s1", 32'(s1), 32'h2);
                check("load2_wa", 32'(WA), 32'(cmd.b));
            end
            P_WAIT: begin
                check("wait_raa", 32'(RAA), 32'(cmd.a));
                check("wait_rab", 32'(RAB), 32'(cmd.b));
                check("wait_re",  32'({REA, REB}), 32'h3);
                check("wait_s2",  32'(s2), 32'd1);
            end
            P_EXEC: begin
                check("exec_s1",  32'(s1),  32'h0);
                check("exec_wa",  32'(WA),  32'(cmd.dst));
                check("exec_raa", 32'(RAA), 32'(cmd.a));
                check("exec_rab", 32'(RAB), 32'(cmd.b));
                check("exec_re",  32'({REA, REB}), 32'h3);
                check("exec_c",   32'(c),   32'(cmd.op));
                check("exec_s2",  32'(s2),  32'd1);
            end
            default: ;
        endcase
    endtask

    // Issue one command from an IDLE negedge and follow it back to IDLE.
    // Inputs are scrambled while busy to show they are ignored there.
    task automatic run_cmd(input cmd_t cmd, input bit hold_go);
        int phases[$];
        check_idle();
        Go   = 1'b1;
        Load = cmd.load;
        Op   = cmd.op;
        SrcA = cmd.a;
        SrcB = cmd.b;
        Dst  = cmd.dst;

        phases = {};
        if (cmd.load) begin
            phases.push_back(P_LOAD1);
            phases.push_back(P_LOAD2);
        end
        phases.push_back(P_WAIT);
        if (int'(cmd.op) < NUM_OPS) begin
            phases.push_back(P_EXEC);
            phases.push_back(P_DONE);
        end else begin
            phases.push_back(P_ERR);
        end

        model_err = 1'b0;
        model_dst = cmd.dst;
        foreach (phases[i]) begin
            @(negedge CLK);
            if (!hold_go) Go = 1'($urandom);
            Op   = 3'($urandom);
            Load = 1'($urandom);
            SrcA = AW'($urandom);
            SrcB = AW'($urandom);
            Dst  = AW'($urandom);
            check_phase(phases[i], cmd);
        end
        if (int'(cmd.op) >= NUM_OPS) model_err = 1'b1;
        @(negedge CLK);
        Go = hold_go;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t r;
        r.load = 1'($urandom);
        r.op   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(NUM_OPS, 7))
                                             : 3'($urandom_range(0, NUM_OPS - 1));
        r.a    = AW'($urandom);
        r.b    = AW'($urandom);
        r.dst  = AW'($urandom);
        return r;
    endfunction

    initial begin
        cmd_t cmd;
        bit   hold;
        bit   prev_hold;

        // Reset state, checked while reset is still applied.
        #1;
        check("rst_cs",   32'(CS_out), 32'd0);
        check("rst_busy", 32'(Busy),   32'd0);
        check("rst_we",   32'(WE),     32'd0);
        check("rst_err",  32'(Err),    32'd0);
        check("rst_raa",  32'(RAA),    32'd0);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        check_idle();

        // Wide-address build: both loads hit 5, EXEC writes 7.
        go3 = 1'b1; load3 = 1'b1; op3 = 3'd2; a3 = 3'd5; b3 = 3'd5; d3 = 3'd7;
        @(negedge CLK);
        go3 = 1'b0; a3 = 3'd1; d3 = 3'd2;
        check("aw3_l1_we", 32'(we3), 32'd1);
        check("aw3_l1_wa", 32'(wa3), 32'd5);
        @(negedge CLK);
        check("aw3_l2_we", 32'(we3), 32'd1);
        check("aw3_l2_wa", 32'(wa3), 32'd5);
        @(negedge CLK);
        check("aw3_wt_we", 32'(we3), 32'd0);
        check("aw3_wt_ra", 32'({raa3, rab3}), 32'({3'd5, 3'd5}));
        @(negedge CLK);
        check("aw3_ex_we", 32'(we3), 32'd1);
        check("aw3_ex_wa", 32'(wa3), 32'd7);
        check("aw3_ex_ra", 32'({raa3, rab3}), 32'({3'd5, 3'd5}));
        @(negedge CLK);
        check("aw3_done",  32'(done3), 32'd1);
        @(negedge CLK);
        check("aw3_idle",  32'(cs3), 32'd0);

        // Directed commands.
        run_cmd('{load: 1'b1, op: 3'd3, a: 2'd0, b: 2'd1, dst: 2'd2}, 1'b0);
        run_cmd('{load: 1'b0, op: 3'd1, a: 2'd2, b: 2'd3, dst: 2'd0}, 1'b0);
        run_cmd('{load: 1'b0, op: 3'd7, a: 2'd1, b: 2'd2, dst: 2'd3}, 1'b0);
        // Err must hold through idle cycles with Go low.
        repeat (2) begin
            check_idle();
            @(negedge CLK);
        end
        run_cmd('{load: 1'b1, op: 3'd6, a: 2'd3, b: 2'd3, dst: 2'd1}, 1'b0);
        run_cmd('{load: 1'b1, op: 3'd0, a: 2'd2, b: 2'd2, dst: 2'd2}, 1'b0);

        // Go held high: back-to-back commands every four cycles.
        for (int i = 0; i < 5; i++) begin
            cmd      = rand_cmd();
            cmd.load = 1'b0;
            cmd.op   = 3'($urandom_range(0, NUM_OPS - 1));
            run_cmd(cmd, 1'b1);
        end
        Go = 1'b0;

        // Randomized command stream with random idle gaps.
        prev_hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            hold = 1'($urandom);
            if (!prev_hold) begin
                repeat ($urandom_range(0, 2)) begin
                    check_idle();
                    @(negedge CLK);
                end
            end
            run_cmd(rand_cmd(), hold);
            prev_hold = hold;
        end
        Go = 1'b0;
        @(negedge CLK);

        // Reset asserted in LOAD2, between clock edges.
        check_idle();
        Go = 1'b1; Load = 1'b1; Op = 3'd2; SrcA = 2'd1; SrcB = 2'd2; Dst = 2'd3;
        @(negedge CLK);
        Go = 1'b0;
        @(posedge CLK);
        #2;
        check("mid_cs_load2", 32'(CS_out), 32'd2);
        check("mid_we_load2", 32'(WE), 32'd1);
        RST_n = 1'b0;
        #1;
        check("mid_rst_we",   32'(WE),     32'd0);
        check("mid_rst_cs",   32'(CS_out), 32'd0);
        check("mid_rst_busy", 32'(Busy),   32'd0);
        check("mid_rst_err",  32'(Err),    32'd0);
        model_err = 1'b0;
        model_dst = '0;
        @(negedge CLK);
        RST_n = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check_idle();
        end
        run_cmd('{load: 1'b0, op: 3'd5, a: 2'd3, b: 2'd0, dst: 2'd1}, 1'b0);
        check_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
